// File: rtl/axi_mmio_master.sv
// Single-beat AXI4 MMIO master: turns one command at a time into an AW/W/B
// or AR/R exchange and presents a completion with read data and error flag.
//
// state | meaning
// IDLE  | ready for a command (req_ready=1 once out of reset)
// WRITE | AW and W beats offered; each tracked independently
// WRESP | waiting for the B response (b_ready=1)
// RADDR | AR beat offered
// RDATA | waiting for the R beat (r_ready=1)
// DONE  | completion presented until resp_ready
module axi_mmio_master #(
    parameter logic [3:0] AXI_ID   = 4'h0,
    parameter bit         CHECK_ID = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [30:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        io_axi4_0_aw_valid,
    input  logic        io_axi4_0_aw_ready,
    output logic [3:0]  io_axi4_0_aw_id,
    output logic [30:0] io_axi4_0_aw_addr,
    output logic [7:0]  io_axi4_0_aw_len,
    output logic [2:0]  io_axi4_0_aw_size,
    output logic [1:0]  io_axi4_0_aw_burst,
    output logic        io_axi4_0_w_valid,
    input  logic        io_axi4_0_w_ready,
    output logic [31:0] io_axi4_0_w_data,
    output logic [3:0]  io_axi4_0_w_strb,
    output logic        io_axi4_0_w_last,
    input  logic        io_axi4_0_b_valid,
    output logic        io_axi4_0_b_ready,
    input  logic [3:0]  io_axi4_0_b_id,
    input  logic [1:0]  io_axi4_0_b_resp,
    output logic        io_axi4_0_ar_valid,
    input  logic        io_axi4_0_ar_ready,
    output logic [3:0]  io_axi4_0_ar_id,
    output logic [30:0] io_axi4_0_ar_addr,
    output logic [7:0]  io_axi4_0_ar_len,
    output logic [2:0]  io_axi4_0_ar_size,
    output logic [1:0]  io_axi4_0_ar_burst,
    input  logic        io_axi4_0_r_valid,
    output logic        io_axi4_0_r_ready,
    input  logic [3:0]  io_axi4_0_r_id,
    input  logic [31:0] io_axi4_0_r_data,
    input  logic [1:0]  io_axi4_0_r_resp,
    input  logic        io_axi4_0_r_last
);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, DONE} state_t;

    state_t      state_q, state_d;
    logic [30:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        write_q, write_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        ar_valid_q, ar_valid_d;
    logic        b_ready_q, b_ready_d;
    logic        r_ready_q, r_ready_d;

    // Next-state and next-output computation; every output is registered so
    // no ready input reaches a valid output combinationally.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = resp_valid_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        ar_valid_d   = ar_valid_q;
        b_ready_d    = b_ready_q;
        r_ready_d    = r_ready_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    write_d   = req_write;
                    rdata_d   = 32'h0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_addr[1:0] != 2'b00) begin
                        err_d        = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else if (req_write) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = WRITE;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = RADDR;
                    end
                end
            end
            WRITE: begin
                if (aw_valid_q && io_axi4_0_aw_ready) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_valid_q && io_axi4_0_w_ready) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    b_ready_d = 1'b1;
                    state_d   = WRESP;
                end
            end
            WRESP: begin
                if (io_axi4_0_b_valid && b_ready_q) begin
                    err_d        = (io_axi4_0_b_resp != 2'b00) ||
                                   (CHECK_ID && (io_axi4_0_b_id != AXI_ID));
                    b_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            RADDR: begin
                if (ar_valid_q && io_axi4_0_ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = RDATA;
                end
            end
            RDATA: begin
                if (io_axi4_0_r_valid && r_ready_q) begin
                    rdata_d      = io_axi4_0_r_data;
                    err_d        = (io_axi4_0_r_resp != 2'b00) ||
                                   (CHECK_ID && (io_axi4_0_r_id != AXI_ID)) ||
                                   !io_axi4_0_r_last;
                    r_ready_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= 31'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            write_q      <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            b_ready_q    <= 1'b0;
            r_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            ar_valid_q   <= ar_valid_d;
            b_ready_q    <= b_ready_d;
            r_ready_q    <= r_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign io_axi4_0_aw_valid = aw_valid_q;
    assign io_axi4_0_aw_id    = AXI_ID;
    assign io_axi4_0_aw_addr  = addr_q;
    assign io_axi4_0_aw_len   = 8'h00;
    assign io_axi4_0_aw_size  = 3'b010;
    assign io_axi4_0_aw_burst = 2'b01;

    assign io_axi4_0_w_valid = w_valid_q;
    assign io_axi4_0_w_data  = wdata_q;
    assign io_axi4_0_w_strb  = wstrb_q;
    assign io_axi4_0_w_last  = 1'b1;

    assign io_axi4_0_b_ready = b_ready_q;

    // write_q only distinguishes the command kind; the FSM path already
    // encodes it, so the address/data channels just mirror the captured command.
    assign io_axi4_0_ar_valid = ar_valid_q & ~write_q;
    assign io_axi4_0_ar_id    = AXI_ID;
    assign io_axi4_0_ar_addr  = addr_q;
    assign io_axi4_0_ar_len   = 8'h00;
    assign io_axi4_0_ar_size  = 3'b010;
    assign io_axi4_0_ar_burst = 2'b01;

    assign io_axi4_0_r_ready = r_ready_q;

endmodule

// File: tb/tb_axi_mmio_master.sv
// Self-checking bench for axi_mmio_master: a reactive single-beat AXI slave
// with programmable delays/responses, and a transaction-level reference model.
module tb_axi_mmio_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [30:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        aw_valid, aw_ready;
    logic [3:0]  aw_id;
    logic [30:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_valid, ar_ready;
    logic [3:0]  ar_id;
    logic [30:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int checks   = 0;
    int failures = 0;

    // slave configuration
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  cfg_b_resp = 2'b00, cfg_r_resp = 2'b00;
    logic [3:0]  cfg_b_id = 4'h0, cfg_r_id = 4'h0;
    logic        cfg_r_last = 1'b1;
    logic [31:0] cfg_r_data = 32'h0;
    bit          slave_en = 1'b1;

    // slave / monitor state
    logic        aw_got = 0, w_got = 0, ar_got = 0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic [30:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    logic [30:0] ar_q[$];
    int          b_cnt = 0, r_cnt = 0, viol = 0;
    int          aw_hi = 0, w_hi = 0, cyc = 0, aw_hs_cyc = 0, bready_cyc = -1;
    logic        aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [30:0] aw_addr_p, ar_addr_p;
    logic [31:0] w_data_p;
    logic [3:0]  w_strb_p;

    always #5 clock = ~clock;

    axi_mmio_master #(.AXI_ID(4'h0), .CHECK_ID(1'b1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_axi4_0_aw_valid(aw_valid), .io_axi4_0_aw_ready(aw_ready),
        .io_axi4_0_aw_id(aw_id), .io_axi4_0_aw_addr(aw_addr),
        .io_axi4_0_aw_len(aw_len), .io_axi4_0_aw_size(aw_size),
        .io_axi4_0_aw_burst(aw_burst),
        .io_axi4_0_w_valid(w_valid), .io_axi4_0_w_ready(w_ready),
        .io_axi4_0_w_data(w_data), .io_axi4_0_w_strb(w_strb),
        .io_axi4_0_w_last(w_last),
        .io_axi4_0_b_valid(b_valid), .io_axi4_0_b_ready(b_ready),
        .io_axi4_0_b_id(b_id), .io_axi4_0_b_resp(b_resp),
        .io_axi4_0_ar_valid(ar_valid), .io_axi4_0_ar_ready(ar_ready),
        .io_axi4_0_ar_id(ar_id), .io_axi4_0_ar_addr(ar_addr),
        .io_axi4_0_ar_len(ar_len), .io_axi4_0_ar_size(ar_size),
        .io_axi4_0_ar_burst(ar_burst),
        .io_axi4_0_r_valid(r_valid), .io_axi4_0_r_ready(r_ready),
        .io_axi4_0_r_id(r_id), .io_axi4_0_r_data(r_data),
        .io_axi4_0_r_resp(r_resp), .io_axi4_0_r_last(r_last)
    );

    // Reactive slave: observes handshakes at the edge, drives 1 time unit later.
    initial begin : slave
        aw_ready = 0; w_ready = 0; ar_ready = 0;
        b_valid = 0; b_id = 0; b_resp = 0;
        r_valid = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0;
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend && (!aw_valid || aw_addr !== aw_addr_p)) viol++;
                if (w_pend && (!w_valid || w_data !== w_data_p || w_strb !== w_strb_p)) viol++;
                if (ar_pend && (!ar_valid || ar_addr !== ar_addr_p)) viol++;
                aw_pend = aw_valid && !aw_ready; aw_addr_p = aw_addr;
                w_pend  = w_valid && !w_ready;   w_data_p = w_data; w_strb_p = w_strb;
                ar_pend = ar_valid && !ar_ready; ar_addr_p = ar_addr;
                if (aw_valid) aw_hi++;
                if (w_valid) w_hi++;
                if (b_ready && bready_cyc < 0) bready_cyc = cyc;
                if (aw_valid && aw_ready) begin
                    aw_q.push_back(aw_addr); aw_got = 1; aw_wait = 0; aw_hs_cyc = cyc;
                    if (aw_id !== 4'h0 || aw_len !== 8'h0 || aw_size !== 3'b010 || aw_burst !== 2'b01) viol++;
                end else if (aw_valid) aw_wait++;
                if (w_valid && w_ready) begin
                    wd_q.push_back(w_data); ws_q.push_back(w_strb); w_got = 1; w_wait = 0;
                    if (w_last !== 1'b1) viol++;
                end else if (w_valid) w_wait++;
                if (ar_valid && ar_ready) begin
                    ar_q.push_back(ar_addr); ar_got = 1; ar_wait = 0;
                    if (ar_id !== 4'h0 || ar_len !== 8'h0 || ar_size !== 3'b010 || ar_burst !== 2'b01) viol++;
                end else if (ar_valid) ar_wait++;
                if (b_valid && b_ready) begin
                    b_cnt++; aw_got = 0; w_got = 0; b_wait = 0;
                end else if (aw_got && w_got && !b_valid) b_wait++;
                if (r_valid && r_ready) begin
                    r_cnt++; ar_got = 0; r_wait = 0;
                end else if (ar_got && !r_valid) r_wait++;
            end
            #1;
            if (slave_en) begin
                if (reset) begin
                    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
                end else begin
                    aw_ready = aw_valid && (aw_wait >= aw_delay);
                    w_ready  = w_valid && (w_wait >= w_delay);
                    ar_ready = ar_valid && (ar_wait >= ar_delay);
                    b_valid  = aw_got && w_got && (b_valid || b_wait > b_delay);
                    b_id = cfg_b_id; b_resp = cfg_b_resp;
                    r_valid  = ar_got && (r_valid || r_wait > r_delay);
                    r_id = cfg_r_id; r_resp = cfg_r_resp; r_last = cfg_r_last; r_data = cfg_r_data;
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_log();
        aw_q.delete(); wd_q.delete(); ws_q.delete(); ar_q.delete();
        aw_hi = 0; w_hi = 0; bready_cyc = -1;
    endtask

    task automatic set_delays(input int awd, input int wd, input int bd, input int ard, input int rd);
        aw_delay = awd; w_delay = wd; b_delay = bd; ar_delay = ard; r_delay = rd;
    endtask

    // Offer a command, wait for acceptance and for resp_valid (both bounded).
    task automatic run_txn(input logic wr, input logic [30:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int acc_wait, output int lat);
        acc_wait = 0;
        req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1'b1;
        while (!req_ready && acc_wait < 20) begin tick(); acc_wait++; end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin tick(); lat++; end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // Transaction-level expectation from the current slave configuration.
    function automatic void model(input logic wr, input logic [30:0] a,
                                  output logic [31:0] rd, output logic er,
                                  output int naw, output int nar, output int lat);
        rd = 32'h0; er = 1'b0; naw = 0; nar = 0; lat = 1;
        if (a % 4 != 0) begin
            er = 1'b1;
        end else if (wr) begin
            naw = 1;
            er  = (cfg_b_resp != 0) || (cfg_b_id != 0);
            lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
        end else begin
            nar = 1;
            rd  = cfg_r_data;
            er  = (cfg_r_resp != 0) || (cfg_r_id != 0) || (cfg_r_last == 0);
            lat = 3 + ar_delay + r_delay;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; resp_ready = 0;
        req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready: got %b exp 0", req_ready); end
        checks++;
        if ({resp_valid, resp_err} !== 2'b00) begin failures++; $display("FAIL reset_resp: got %b%b exp 00", resp_valid, resp_err); end
        checks++;
        if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata); end
        checks++;
        if ({aw_valid, w_valid, ar_valid, b_ready, r_ready} !== 5'b0) begin
            failures++; $display("FAIL reset_axi: got %b exp 00000", {aw_valid, w_valid, ar_valid, b_ready, r_ready});
        end
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_release_early: got %b exp 0", req_ready); end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_write_basic();
        int aw8, lat; int b0;
        set_delays(0, 0, 0, 0, 0); clear_log(); b0 = b_cnt;
        run_txn(1'b1, 31'h60000004, 32'hDEADBEEF, 4'hF, aw8, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL wr_basic_lat: got %0d exp 3", lat); end
        checks++;
        if ({resp_err, resp_rdata} !== 33'h0) begin failures++; $display("FAIL wr_basic_resp: got err=%b rdata=%h exp 0/0", resp_err, resp_rdata); end
        checks++;
        if (aw_q.size() != 1 || wd_q.size() != 1 || ar_q.size() != 0) begin
            failures++; $display("FAIL wr_basic_beats: got aw=%0d w=%0d ar=%0d exp 1/1/0", aw_q.size(), wd_q.size(), ar_q.size());
        end else begin
            checks++;
            if (aw_q[0] !== 31'h60000004 || wd_q[0] !== 32'hDEADBEEF || ws_q[0] !== 4'hF) begin
                failures++; $display("FAIL wr_basic_data: got %h %h %h exp 60000004 deadbeef f", aw_q[0], wd_q[0], ws_q[0]);
            end
        end
        finish_resp();
        checks++;
        if (b_cnt - b0 != 1) begin failures++; $display("FAIL wr_basic_bcnt: got %0d exp 1", b_cnt - b0); end
    endtask

    task automatic test_write_aw_delay();
        int aw8, lat; int b0;
        set_delays(4, 0, 0, 0, 0); clear_log(); b0 = b_cnt;
        run_txn(1'b1, 31'h60000010, 32'hA5A5_0001, 4'h3, aw8, lat);
        checks++;
        if (w_hi != 1) begin failures++; $display("FAIL awdly_w_cycles: got %0d exp 1", w_hi); end
        checks++;
        if (aw_hi != 5) begin failures++; $display("FAIL awdly_aw_cycles: got %0d exp 5", aw_hi); end
        checks++;
        if (bready_cyc != aw_hs_cyc + 1) begin failures++; $display("FAIL awdly_bready: got cyc %0d exp %0d", bready_cyc, aw_hs_cyc + 1); end
        checks++;
        if (lat !== 7) begin failures++; $display("FAIL awdly_lat: got %0d exp 7", lat); end
        finish_resp();
        checks++;
        if (b_cnt - b0 != 1 || resp_valid !== 1'b0) begin
            failures++; $display("FAIL awdly_once: got bcnt=%0d resp_valid=%b exp 1/0", b_cnt - b0, resp_valid);
        end
        set_delays(0, 0, 0, 0, 0);
    endtask

    task automatic test_read_basic();
        int aw8, lat;
        clear_log(); cfg_r_data = 32'h12345678;
        run_txn(1'b0, 31'h60000008, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL rd_basic_lat: got %0d exp 3", lat); end
        checks++;
        if (resp_rdata !== 32'h12345678 || resp_err !== 1'b0) begin
            failures++; $display("FAIL rd_basic_resp: got rdata=%h err=%b exp 12345678/0", resp_rdata, resp_err);
        end
        checks++;
        if (ar_q.size() != 1 || aw_q.size() != 0 || (ar_q.size() == 1 && ar_q[0] !== 31'h60000008)) begin
            failures++; $display("FAIL rd_basic_beats: got ar=%0d aw=%0d exp 1/0", ar_q.size(), aw_q.size());
        end
        finish_resp();
    endtask

    task automatic test_errors();
        int aw8, lat;
        cfg_r_resp = 2'b10; cfg_r_data = 32'hCAFE0000;
        run_txn(1'b0, 31'h00000020, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'hCAFE0000) begin
            failures++; $display("FAIL err_rresp: got err=%b rdata=%h exp 1/cafe0000", resp_err, resp_rdata);
        end
        finish_resp();
        cfg_r_resp = 2'b00; cfg_r_last = 1'b0;
        run_txn(1'b0, 31'h00000024, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (resp_err !== 1'b1) begin failures++; $display("FAIL err_rlast: got %b exp 1", resp_err); end
        finish_resp();
        cfg_r_last = 1'b1; cfg_b_id = 4'h3;
        run_txn(1'b1, 31'h00000030, 32'h11112222, 4'h1, aw8, lat);
        checks++;
        if (resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL err_bid: got err=%b rdata=%h exp 1/0", resp_err, resp_rdata);
        end
        finish_resp();
        cfg_b_id = 4'h0;
    endtask

    task automatic test_misaligned();
        int aw8, lat;
        clear_log();
        run_txn(1'b1, 31'h60000002, 32'h55555555, 4'hF, aw8, lat);
        checks++;
        if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL misal_wr: got lat=%0d err=%b rdata=%h exp 1/1/0", lat, resp_err, resp_rdata);
        end
        finish_resp();
        run_txn(1'b0, 31'h00000103, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (lat !== 1 || resp_err !== 1'b1) begin failures++; $display("FAIL misal_rd: got lat=%0d err=%b exp 1/1", lat, resp_err); end
        finish_resp();
        checks++;
        if (aw_hi + w_hi + aw_q.size() + ar_q.size() != 0) begin
            failures++; $display("FAIL misal_traffic: got aw_cyc=%0d w_cyc=%0d ar=%0d exp none", aw_hi, w_hi, ar_q.size());
        end
    endtask

    task automatic test_spurious();
        int aw8, lat;
        slave_en = 1'b0;
        tick();
        b_valid = 1'b1; b_resp = 2'b10; r_valid = 1'b1; r_resp = 2'b10; r_data = 32'hBAD0BAD0;
        repeat (3) tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL spurious_idle: got resp_valid=%b req_ready=%b exp 0/1", resp_valid, req_ready);
        end
        b_valid = 1'b0; r_valid = 1'b0;
        slave_en = 1'b1;
        tick();
        cfg_r_data = 32'h0BADF00D;
        run_txn(1'b0, 31'h00000040, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (resp_err !== 1'b0 || resp_rdata !== 32'h0BADF00D) begin
            failures++; $display("FAIL spurious_after: got err=%b rdata=%h exp 0/0badf00d", resp_err, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_back_to_back();
        int aw8, lat;
        run_txn(1'b1, 31'h00000200, 32'h01020304, 4'hC, aw8, lat);
        finish_resp();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b exp 1", req_ready); end
        cfg_r_data = 32'h89ABCDEF;
        run_txn(1'b0, 31'h00000204, 32'h0, 4'h0, aw8, lat);
        checks++;
        if (aw8 != 0 || lat != 3 || resp_rdata !== 32'h89ABCDEF) begin
            failures++; $display("FAIL b2b_second: got wait=%0d lat=%0d rdata=%h exp 0/3/89abcdef", aw8, lat, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_hold_and_reset();
        int aw8, lat, n, b0;
        logic [31:0] rd0; logic er0;
        cfg_r_data = 32'h76543210;
        run_txn(1'b0, 31'h00000300, 32'h0, 4'h0, aw8, lat);
        rd0 = 32'h76543210; er0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== er0) begin
                failures++; $display("FAIL hold_c%0d: got v=%b rdata=%h err=%b exp 1/%h/%b", i, resp_valid, resp_rdata, resp_err, rd0, er0);
            end
            tick();
        end
        finish_resp();
        set_delays(0, 0, 20, 0, 0); b0 = b_cnt;
        req_write = 1'b1; req_addr = 31'h00000400; req_wdata = 32'h1; req_wstrb = 4'hF; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!b_ready && n < 20) begin tick(); n++; end
        checks++;
        if (b_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_wresp: got b_ready=%b exp 1", b_ready); end
        reset = 1'b1;
        tick();
        checks++;
        if ({req_ready, resp_valid, resp_err, aw_valid, w_valid, ar_valid, b_ready, r_ready} !== 8'h0 || resp_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_mid_outputs: got %b rdata=%h exp 0",
                {req_ready, resp_valid, resp_err, aw_valid, w_valid, ar_valid, b_ready, r_ready}, resp_rdata);
        end
        reset = 1'b0;
        set_delays(0, 0, 0, 0, 0);
        tick();
        checks++;
        if (req_ready !== 1'b1 || b_cnt != b0) begin
            failures++; $display("FAIL rst_mid_release: got req_ready=%b bcnt_delta=%0d exp 1/0", req_ready, b_cnt - b0);
        end
    endtask

    task automatic test_random();
        int aw8, lat, exp_lat, naw, nar;
        logic wr; logic [30:0] a; logic [31:0] d; logic [3:0] s;
        logic [31:0] exp_rd; logic exp_er;
        for (int it = 0; it < 40; it++) begin
            wr = $urandom_range(1, 0);
            a  = 31'($urandom);
            if ($urandom_range(4, 0) != 0) a[1:0] = 2'b00;
            d  = $urandom; s = 4'($urandom);
            set_delays($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                       $urandom_range(3, 0), $urandom_range(3, 0));
            cfg_b_resp = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
            cfg_r_resp = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
            cfg_b_id   = ($urandom_range(5, 0) == 0) ? 4'($urandom) : 4'h0;
            cfg_r_id   = ($urandom_range(5, 0) == 0) ? 4'($urandom) : 4'h0;
            cfg_r_last = ($urandom_range(7, 0) != 0);
            cfg_r_data = $urandom;
            model(wr, a, exp_rd, exp_er, naw, nar, exp_lat);
            clear_log();
            run_txn(wr, a, d, s, aw8, lat);
            checks++;
            if (lat != exp_lat || resp_rdata !== exp_rd || resp_err !== exp_er) begin
                failures++; $display("FAIL rand_%0d_resp: got lat=%0d rdata=%h err=%b exp %0d/%h/%b",
                                     it, lat, resp_rdata, resp_err, exp_lat, exp_rd, exp_er);
            end
            checks++;
            if (aw_q.size() != naw || wd_q.size() != naw || ar_q.size() != nar) begin
                failures++; $display("FAIL rand_%0d_beats: got aw=%0d w=%0d ar=%0d exp %0d/%0d/%0d",
                                     it, aw_q.size(), wd_q.size(), ar_q.size(), naw, naw, nar);
            end else if (naw == 1) begin
                checks++;
                if (aw_q[0] !== a || wd_q[0] !== d || ws_q[0] !== s) begin
                    failures++; $display("FAIL rand_%0d_wbeat: got %h %h %h exp %h %h %h", it, aw_q[0], wd_q[0], ws_q[0], a, d, s);
                end
            end else if (nar == 1) begin
                checks++;
                if (ar_q[0] !== a) begin failures++; $display("FAIL rand_%0d_arbeat: got %h exp %h", it, ar_q[0], a); end
            end
            if ($urandom_range(2, 0) == 0) repeat ($urandom_range(3, 1)) tick();
            finish_resp();
        end
        set_delays(0, 0, 0, 0, 0);
        cfg_b_resp = 0; cfg_r_resp = 0; cfg_b_id = 0; cfg_r_id = 0; cfg_r_last = 1;
    endtask

    task automatic test_protocol();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL protocol_violations: got %0d exp 0", viol); end
    endtask

    initial begin : main
        reset = 1'b1; req_valid = 0; resp_ready = 0;
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_basic();
        test_errors();
        test_misaligned();
        test_spurious();
        test_back_to_back();
        test_hold_and_reset();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
